// File: rtl/playlist_ctrl.sv
// Transport/playlist controller: turns button pulses and song_done into play, reset_play and
// a track index, with loop-all, repeat-one, shuffle and stop-at-end playback modes.
module playlist_ctrl #(
  parameter int unsigned NUM_SONGS = 5,
  parameter int unsigned SONG_W    = 3,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_pause,
  input  logic              next,
  input  logic              prev,
  input  logic              song_done,
  input  logic [1:0]        mode,
  output logic              play,
  output logic              reset_play,
  output logic [SONG_W-1:0] song
);

  typedef enum logic [1:0] {
    StStop,
    StPause,
    StPlay,
    StLoad
  } state_e;

  localparam logic [1:0] ModeLoopAll   = 2'b00;
  localparam logic [1:0] ModeRepeatOne = 2'b01;
  localparam logic [1:0] ModeShuffle   = 2'b10;
  localparam logic [1:0] ModeStopEnd   = 2'b11;

  localparam logic [SONG_W-1:0] LastSong = SONG_W'(NUM_SONGS - 1);

  state_e            r_state, w_state_d;
  logic [SONG_W-1:0] r_song, w_song_d;
  logic [SONG_W-1:0] r_hist, w_hist_d;
  logic [7:0]        r_lfsr, w_lfsr_d;

  logic [SONG_W-1:0] w_inc, w_dec, w_cand, w_pick, w_skip_song;
  logic              w_fb;

  // Wrapping increment; >= keeps any out-of-range value from escaping the track range.
  function automatic logic [SONG_W-1:0] f_inc(input logic [SONG_W-1:0] s);
    return (s >= LastSong) ? '0 : s + SONG_W'(1);
  endfunction

  assign w_inc = f_inc(r_song);
  assign w_dec = (r_song == '0) ? LastSong : r_song - SONG_W'(1);

  // Shuffle pick: bump the candidate forward when it would replay the current track.
  assign w_cand = SONG_W'(32'(r_lfsr) % NUM_SONGS);
  assign w_pick = (w_cand == r_song) ? f_inc(w_cand) : w_cand;

  assign w_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_lfsr_d = {r_lfsr[6:0], w_fb};

  always_comb begin
    w_skip_song = r_song;
    if (next) begin
      w_skip_song = (mode == ModeShuffle) ? w_pick : w_inc;
    end else if (prev) begin
      w_skip_song = (mode == ModeShuffle) ? r_hist : w_dec;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_song_d  = r_song;
    unique case (r_state)
      StStop: w_state_d = StPause;
      StPause: begin
        if (play_pause) begin
          w_state_d = StPlay;
        end else if (next || prev) begin
          w_state_d = StLoad;
          w_song_d  = w_skip_song;
        end
      end
      StPlay: begin
        if (play_pause) begin
          w_state_d = StPause;
        end else if (next || prev) begin
          w_state_d = StLoad;
          w_song_d  = w_skip_song;
        end else if (song_done) begin
          w_state_d = StLoad;
          unique case (mode)
            ModeLoopAll:   w_song_d = w_inc;
            ModeRepeatOne: w_song_d = r_song;
            ModeShuffle:   w_song_d = w_pick;
            ModeStopEnd: begin
              if (r_song == LastSong) begin
                w_state_d = StStop;
                w_song_d  = '0;
              end else begin
                w_song_d = w_inc;
              end
            end
            default: w_song_d = r_song;
          endcase
        end
      end
      StLoad:  w_state_d = StPlay;
      default: w_state_d = StStop;
    endcase
    w_hist_d = (w_song_d != r_song) ? r_song : r_hist;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StStop;
      r_song  <= '0;
      r_hist  <= '0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_state <= w_state_d;
      r_song  <= w_song_d;
      r_hist  <= w_hist_d;
      r_lfsr  <= w_lfsr_d;
    end
  end

  assign play       = (r_state == StPlay);
  assign reset_play = (r_state == StStop) || (r_state == StLoad);
  assign song       = r_song;

endmodule

// File: tb/tb_playlist_ctrl.sv
// Directed self-checking bench for playlist_ctrl with NUM_SONGS=5, SONG_W=3.
module tb_playlist_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_pause, next, prev, song_done;
  logic [1:0] mode;
  logic       play, reset_play;
  logic [2:0] song;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] prev_s, old_s;

  playlist_ctrl #(
    .NUM_SONGS(5),
    .SONG_W   (3),
    .LFSR_SEED(8'hA5)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .play_pause(play_pause),
    .next      (next),
    .prev      (prev),
    .song_done (song_done),
    .mode      (mode),
    .play      (play),
    .reset_play(reset_play),
    .song      (song)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic pp, input logic nx, input logic pv, input logic sd);
    play_pause = pp;
    next       = nx;
    prev       = pv;
    song_done  = sd;
    tick();
    play_pause = 1'b0;
    next       = 1'b0;
    prev       = 1'b0;
    song_done  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic p, input logic rp, input logic [2:0] s);
    check({tag, "_play"}, 32'(play), 32'(p));
    check({tag, "_rp"}, 32'(reset_play), 32'(rp));
    check({tag, "_song"}, 32'(song), 32'(s));
  endtask

  initial begin
    reset = 1'b0;
    play_pause = 1'b0;
    next = 1'b0;
    prev = 1'b0;
    song_done = 1'b0;
    mode = 2'b00;
    #2;
    check_out("in_reset", 1'b0, 1'b1, 3'd0);
    #10 reset = 1'b1;
    #1;
    check_out("stop0", 1'b0, 1'b1, 3'd0);
    tick();
    check_out("pause1", 1'b0, 1'b0, 3'd0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check_out("play_on", 1'b1, 1'b0, 3'd0);

    // Loop-all skips up to the last track
    for (int i = 1; i <= 4; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      check_out("next_load", 1'b0, 1'b1, 3'(i));
      tick();
    end
    check("next_play", 32'(play), 32'd1);

    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_out("done_wrap", 1'b0, 1'b1, 3'd0);
    tick();
    check_out("done_wrap_play", 1'b1, 1'b0, 3'd0);

    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    mode = 2'b01;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_out("repeat_load", 1'b0, 1'b1, 3'd2);
    tick();
    check_out("repeat_play", 1'b1, 1'b0, 3'd2);

    mode = 2'b11;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_out("stopend_mid", 1'b0, 1'b1, 3'd3);
    tick();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stopend_at4", 32'(song), 32'd4);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_out("stopend_stop", 1'b0, 1'b1, 3'd0);
    tick();
    check_out("stopend_pause", 1'b0, 1'b0, 3'd0);

    mode = 2'b00;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check_out("prev_wrap", 1'b0, 1'b1, 3'd4);
    tick();
    check_out("prev_resume", 1'b1, 1'b0, 3'd4);

    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check_out("next_over_prev", 1'b0, 1'b1, 3'd0);
    tick();

    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check_out("pp_over_next", 1'b0, 1'b0, 3'd0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("pp_resume", 32'(play), 32'd1);

    // next held through LOAD must not skip twice
    next = 1'b1;
    tick();
    tick();
    next = 1'b0;
    check_out("load_ignore", 1'b1, 1'b0, 3'd1);

    mode   = 2'b10;
    prev_s = song;
    for (int i = 0; i < 30; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      check("shuf_range", 32'(song < 3'd5), 32'd1);
      check("shuf_norep", 32'(song != prev_s), 32'd1);
      prev_s = song;
      tick();
    end
    old_s = song;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("shuf_moved", 32'(song != old_s), 32'd1);
    tick();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("shuf_hist", 32'(song), 32'(old_s));
    tick();
    old_s = song;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("shuf_done_norep", 32'(song != old_s && song < 3'd5), 32'd1);
    tick();

    mode = 2'b00;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_reset_load", 32'(reset_play), 32'd1);
    reset = 1'b0;
    #1;
    check_out("reset_in_load", 1'b0, 1'b1, 3'd0);
    #3 reset = 1'b1;
    tick();
    check_out("after_reset", 1'b0, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
